// File: rtl/irq_pending_ctrl.sv
// Machine-mode interrupt pending/arbitration: builds mip, masks with mie/mstatus.MIE, holds a req/ack handshake to the trap logic.
// Latency: input -> mip_o one edge; mip_o -> irq_req_o one further edge. Request is held until irq_ack_i or withdrawn.
module irq_pending_ctrl #(
    parameter bit MEI_EDGE = 1'b0,
    parameter bit MSI_EDGE = 1'b0,
    parameter bit MTI_EDGE = 1'b0
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        mei_i,
    input  logic        msi_i,
    input  logic        mti_i,
    input  logic [31:0] mie_i,
    input  logic        mstatus_mie_i,
    input  logic        mip_we_i,
    input  logic [31:0] mip_wdata_i,
    input  logic        irq_ack_i,
    output logic [31:0] mip_o,
    output logic        irq_req_o,
    output logic [3:0]  irq_cause_o
);

    localparam logic [3:0] CAUSE_MEI = 4'd11;
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t state;
    logic   meip, msip, mtip;
    logic   mei_q, msi_q, mti_q;
    logic   ack_fire;
    logic   en_mei, en_msi, en_mti;
    logic   cause_en;
    logic   unused_csr_bits;

    assign unused_csr_bits = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0],
                               mip_wdata_i[31:12], mip_wdata_i[10:8],
                               mip_wdata_i[6:4], mip_wdata_i[2:0]};

    // A new rising edge beats any clear arriving in the same cycle.
    function automatic logic pend_next(input logic edge_mode, input logic pend,
                                       input logic in, input logic hist,
                                       input logic ack_clr, input logic we,
                                       input logic wbit);
        if (!edge_mode)
            return in;
        if (in && !hist)
            return 1'b1;
        if (ack_clr || (we && !wbit))
            return 1'b0;
        return pend;
    endfunction

    assign ack_fire = (state == REQ) && irq_ack_i;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            meip  <= 1'b0;
            msip  <= 1'b0;
            mtip  <= 1'b0;
            mei_q <= 1'b0;
            msi_q <= 1'b0;
            mti_q <= 1'b0;
        end else begin
            mei_q <= mei_i;
            msi_q <= msi_i;
            mti_q <= mti_i;
            meip  <= pend_next(MEI_EDGE, meip, mei_i, mei_q,
                               ack_fire && (irq_cause_o == CAUSE_MEI),
                               mip_we_i, mip_wdata_i[11]);
            msip  <= pend_next(MSI_EDGE, msip, msi_i, msi_q,
                               ack_fire && (irq_cause_o == CAUSE_MSI),
                               mip_we_i, mip_wdata_i[3]);
            mtip  <= pend_next(MTI_EDGE, mtip, mti_i, mti_q,
                               ack_fire && (irq_cause_o == CAUSE_MTI),
                               mip_we_i, mip_wdata_i[7]);
        end
    end

    assign mip_o = {20'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0};

    assign en_mei = meip & mie_i[11] & mstatus_mie_i;
    assign en_msi = msip & mie_i[3]  & mstatus_mie_i;
    assign en_mti = mtip & mie_i[7]  & mstatus_mie_i;

    // Enable of the cause already committed to the core, used for withdrawal.
    assign cause_en = ((irq_cause_o == CAUSE_MEI) && mie_i[11]) ||
                      ((irq_cause_o == CAUSE_MSI) && mie_i[3])  ||
                      ((irq_cause_o == CAUSE_MTI) && mie_i[7]);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            irq_req_o   <= 1'b0;
            irq_cause_o <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_mei || en_msi || en_mti) begin
                        state     <= REQ;
                        irq_req_o <= 1'b1;
                        if (en_mei)
                            irq_cause_o <= CAUSE_MEI;
                        else if (en_msi)
                            irq_cause_o <= CAUSE_MSI;
                        else
                            irq_cause_o <= CAUSE_MTI;
                    end
                end
                REQ: begin
                    if (irq_ack_i) begin
                        state     <= HOLD;
                        irq_req_o <= 1'b0;
                    end else if (!mstatus_mie_i || !cause_en) begin
                        state     <= IDLE;
                        irq_req_o <= 1'b0;
                    end
                end
                HOLD: state <= IDLE;
                default: begin
                    state     <= IDLE;
                    irq_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed scoreboard bench for irq_pending_ctrl with MEI edge-latched, MSI/MTI level.
module tb_irq_pending_ctrl;

    logic        aclk = 1'b0;
    logic        areset;
    logic        mei_i, msi_i, mti_i;
    logic [31:0] mie_i;
    logic        mstatus_mie_i;
    logic        mip_we_i;
    logic [31:0] mip_wdata_i;
    logic        irq_ack_i;
    logic [31:0] mip_o;
    logic        irq_req_o;
    logic [3:0]  irq_cause_o;

    typedef struct {
        string       tag;
        logic [31:0] mip;
        logic        req;
        logic [3:0]  cause;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    irq_pending_ctrl #(.MEI_EDGE(1'b1), .MSI_EDGE(1'b0), .MTI_EDGE(1'b0)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .mei_i         (mei_i),
        .msi_i         (msi_i),
        .mti_i         (mti_i),
        .mie_i         (mie_i),
        .mstatus_mie_i (mstatus_mie_i),
        .mip_we_i      (mip_we_i),
        .mip_wdata_i   (mip_wdata_i),
        .irq_ack_i     (irq_ack_i),
        .mip_o         (mip_o),
        .irq_req_o     (irq_req_o),
        .irq_cause_o   (irq_cause_o)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Push the expectation for the coming edge, then pop and compare just after it.
    task automatic cyc(input string tag, input logic [31:0] mip, input logic req, input logic [3:0] cause);
        exp_t e;
        exp_q.push_back('{tag, mip, req, cause});
        @(posedge aclk);
        #1;
        e = exp_q.pop_front();
        chk({e.tag, ".mip"},   mip_o,               e.mip);
        chk({e.tag, ".req"},   {31'b0, irq_req_o},  {31'b0, e.req});
        chk({e.tag, ".cause"}, {28'b0, irq_cause_o}, {28'b0, e.cause});
    endtask

    initial begin
        areset = 1'b1;
        mei_i = 1'b1; msi_i = 1'b1; mti_i = 1'b1;
        mie_i = '1; mstatus_mie_i = 1'b1;
        mip_we_i = 1'b1; mip_wdata_i = '1; irq_ack_i = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst.mip",   mip_o,                 32'h0);
        chk("rst.req",   {31'b0, irq_req_o},    32'h0);
        chk("rst.cause", {28'b0, irq_cause_o},  32'h0);

        // MEI held high across reset release must register as an edge.
        msi_i = 0; mti_i = 0; mie_i = 0; mstatus_mie_i = 0;
        mip_we_i = 0; mip_wdata_i = 0; irq_ack_i = 0;
        areset = 1'b0;
        cyc("rel_edge", 32'h800, 0, 0);
        mei_i = 0;
        cyc("sticky", 32'h800, 0, 0);

        mip_we_i = 1; mip_wdata_i = 32'h0;
        cyc("csr_clr", 32'h0, 0, 0);
        mip_wdata_i = 32'h808;
        cyc("csr_wr1", 32'h0, 0, 0);
        msi_i = 1; mip_wdata_i = 32'h0;
        cyc("msi_wr", 32'h8, 0, 0);
        mip_we_i = 0; msi_i = 0;
        cyc("msi_low", 32'h0, 0, 0);

        // Level MTI path and handshake timing.
        mie_i = 32'h888; mstatus_mie_i = 1; mti_i = 1;
        cyc("mti_pend", 32'h80, 0, 0);
        cyc("mti_req", 32'h80, 1, 7);
        cyc("mti_hold", 32'h80, 1, 7);
        irq_ack_i = 1;
        cyc("mti_ack", 32'h80, 0, 7);
        irq_ack_i = 0;
        cyc("mti_dead", 32'h80, 0, 7);
        cyc("mti_rereq", 32'h80, 1, 7);

        mstatus_mie_i = 0;
        cyc("wd_drop", 32'h80, 0, 7);
        cyc("wd_idle", 32'h80, 0, 7);
        mstatus_mie_i = 1;
        cyc("wd_rereq", 32'h80, 1, 7);
        irq_ack_i = 1; mstatus_mie_i = 0;
        cyc("ackwd", 32'h80, 0, 7);
        irq_ack_i = 0; mstatus_mie_i = 1;
        cyc("ackwd_hold", 32'h80, 0, 7);
        cyc("ackwd_req", 32'h80, 1, 7);
        mie_i = 32'h808;
        cyc("wd_mie", 32'h80, 0, 7);
        mie_i = 32'h888;
        cyc("mie_back", 32'h80, 1, 7);

        mti_i = 0;
        cyc("lvl_fall", 32'h0, 1, 7);
        irq_ack_i = 1;
        cyc("lvl_ack", 32'h0, 0, 7);
        irq_ack_i = 0;
        cyc("lvl_dead", 32'h0, 0, 7);
        cyc("lvl_idle", 32'h0, 0, 7);

        // Priority and frozen cause.
        mei_i = 1; msi_i = 1; mti_i = 1;
        cyc("pri_pend", 32'h888, 0, 7);
        cyc("pri_req", 32'h888, 1, 11);
        irq_ack_i = 1;
        cyc("pri_ack", 32'h088, 0, 11);
        irq_ack_i = 0;
        cyc("pri_dead", 32'h088, 0, 11);
        cyc("pri_msi", 32'h088, 1, 3);
        mei_i = 0;
        cyc("frz_a", 32'h088, 1, 3);
        mei_i = 1;
        cyc("frz_b", 32'h888, 1, 3);
        cyc("frz_c", 32'h888, 1, 3);
        irq_ack_i = 1;
        cyc("frz_ack", 32'h888, 0, 3);
        irq_ack_i = 0;
        cyc("frz_dead", 32'h888, 0, 3);
        cyc("frz_mei", 32'h888, 1, 11);

        // New MEI edge in the ack cycle keeps the bit pending.
        msi_i = 0; mti_i = 0;
        cyc("set_a", 32'h800, 1, 11);
        mei_i = 0;
        cyc("set_b", 32'h800, 1, 11);
        mei_i = 1; irq_ack_i = 1;
        cyc("set_ack", 32'h800, 0, 11);
        mei_i = 0; irq_ack_i = 0;
        cyc("set_dead", 32'h800, 0, 11);
        cyc("set_req", 32'h800, 1, 11);
        irq_ack_i = 1;
        cyc("clr_ack", 32'h0, 0, 11);
        irq_ack_i = 0;
        cyc("clr_idle", 32'h0, 0, 11);

        mstatus_mie_i = 0; mei_i = 1;
        cyc("idle_pend", 32'h800, 0, 11);
        mei_i = 0; irq_ack_i = 1;
        cyc("idle_ack", 32'h800, 0, 11);
        irq_ack_i = 0; mstatus_mie_i = 1;
        cyc("ar_req", 32'h800, 1, 11);

        // Asynchronous reset mid-request.
        #2;
        areset = 1'b1;
        #1;
        chk("ar.req", {31'b0, irq_req_o}, 32'h0);
        chk("ar.mip", mip_o, 32'h0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        cyc("ar_after", 32'h0, 0, 0);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
